// File: rtl/nes_pad_reader_if.sv
// Pad-side and CPU-side signals of the NES pad reader, bundled for the reader and its host.
interface nes_pad_reader_if;
    logic        pad_data;
    logic        rd_clear;
    logic        pad_latch;
    logic        pad_pulse;
    logic [15:0] game_word;
    logic        frame_valid;

    modport master (
        output pad_data, rd_clear,
        input  pad_latch, pad_pulse, game_word, frame_valid
    );

    modport slave (
        input  pad_data, rd_clear,
        output pad_latch, pad_pulse, game_word, frame_valid
    );
endinterface

// File: rtl/nes_pad_reader.sv
// Polls an NES serial pad and presents {sticky new-press bits, live buttons} to the CPU.
// Optional PAD_DEBOUNCE_EN: commit a frame only when it matches the previous raw frame.
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | waiting for a poll request
// ST_LATCH    | pad_latch high for 2*TICK_CYC cycles
// ST_SETTLE   | pad_latch low for TICK_CYC cycles before bit 0
// ST_SAMPLE   | capture one button bit from the synchronised line
// ST_PULSE_HI | pad_pulse high for TICK_CYC cycles
// ST_PULSE_LO | pad_pulse low for TICK_CYC cycles
// ST_DONE     | commit the frame to buttons / sticky bits
module nes_pad_reader #(
    parameter int TICK_CYC = 300,
    parameter int POLL_DIV = 833333
) (
    input  logic              clk_i,
    input  logic              reset_i,
    nes_pad_reader_if.slave   pad_if
);
    localparam int TW = $clog2(2 * TICK_CYC);
    localparam int PW = $clog2(POLL_DIV);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic            pend_q, pend_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      buttons_q, buttons_d;
    logic [7:0]      sticky_q, sticky_d;
    logic            fv_q, fv_d;
    logic            latch_q, latch_d;
    logic            pulse_q, pulse_d;
    logic            sync1_q, sync2_q;
    logic            poll_wrap, req, commit;
    logic [7:0]      sticky_base;
`ifdef PAD_DEBOUNCE_EN
    logic [7:0]      cand_q, cand_d;
`endif

    always_comb begin
        poll_wrap   = (poll_q == PW'(POLL_DIV - 1));
        poll_d      = poll_wrap ? '0 : poll_q + 1'b1;
        req         = pend_q | poll_wrap;
        // Only one request is held; it is consumed when IDLE sees it.
        pend_d      = req & (state_q != ST_IDLE);
        state_d     = state_q;
        tick_d      = (tick_q != '0) ? tick_q - 1'b1 : tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        buttons_d   = buttons_q;
        sticky_base = pad_if.rd_clear ? 8'h00 : sticky_q;
        sticky_d    = sticky_base;
`ifdef PAD_DEBOUNCE_EN
        cand_d      = cand_q;
        commit      = (shift_q == cand_q);
`else
        commit      = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                bit_d = 3'd0;
                if (req) state_d = ST_LATCH;
            end
            ST_LATCH:    if (tick_q == '0) state_d = ST_SETTLE;
            ST_SETTLE:   if (tick_q == '0) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                shift_d[bit_q] = ~sync2_q;
                if (bit_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    state_d = ST_PULSE_HI;
                end
            end
            ST_PULSE_HI: if (tick_q == '0) state_d = ST_PULSE_LO;
            ST_PULSE_LO: if (tick_q == '0) state_d = ST_SAMPLE;
            ST_DONE: begin
                if (commit) begin
                    sticky_d  = sticky_base | (shift_q & ~buttons_q);
                    buttons_d = shift_q;
                end
`ifdef PAD_DEBOUNCE_EN
                cand_d = shift_q;
`endif
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ST_LATCH:    tick_d = TW'(2 * TICK_CYC - 1);
                ST_SETTLE,
                ST_PULSE_HI,
                ST_PULSE_LO: tick_d = TW'(TICK_CYC - 1);
                default:     tick_d = '0;
            endcase
        end

        latch_d = (state_d == ST_LATCH);
        pulse_d = (state_d == ST_PULSE_HI);
        fv_d    = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            poll_q    <= '0;
            pend_q    <= 1'b0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            buttons_q <= 8'h00;
            sticky_q  <= 8'h00;
            fv_q      <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            poll_q    <= poll_d;
            pend_q    <= pend_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            sticky_q  <= sticky_d;
            fv_q      <= fv_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            sync1_q   <= pad_if.pad_data;
            sync2_q   <= sync1_q;
        end
    end

`ifdef PAD_DEBOUNCE_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cand_q <= 8'h00;
        else         cand_q <= cand_d;
    end
`endif

    assign pad_if.pad_latch   = latch_q;
    assign pad_if.pad_pulse   = pulse_q;
    assign pad_if.game_word   = {sticky_q, buttons_q};
    assign pad_if.frame_valid = fv_q;
endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a byte-shifting pad model; honours PAD_DEBOUNCE_EN.
module tb_nes_pad_reader;
    localparam int TICK = 4;
    localparam int PDIV = 2000;
`ifdef PAD_DEBOUNCE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nes_pad_reader_if pif();

    nes_pad_reader #(.TICK_CYC(TICK), .POLL_DIV(PDIV)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .pad_if  (pif)
    );

    // Pad model: latch loads the raw active-low byte, each pulse rising edge shifts the next bit out.
    logic [7:0] pad_byte = 8'hFF;
    logic [3:0] pad_cnt  = 4'd8;
    logic       pulse_prev = 1'b0;
    always @(posedge clk) begin
        if (pif.pad_latch)                         pad_cnt <= 4'd0;
        else if (pif.pad_pulse && !pulse_prev)     pad_cnt <= pad_cnt + 4'd1;
        pulse_prev <= pif.pad_pulse;
    end
    assign pif.pad_data = (pad_cnt < 4'd8) ? pad_byte[pad_cnt[2:0]] : 1'b1;

    int total = 0;
    int bad   = 0;

    task automatic wait_fv(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(posedge clk); #1;
            n++;
            if (pif.frame_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_latch(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(posedge clk); #1;
            n++;
            if (pif.pad_latch) begin ok = 1'b1; break; end
        end
    endtask

    task automatic skip_frames(input int k);
        int n; bit ok;
        for (int i = 0; i < k; i++) begin
            wait_fv(n, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL skip_frame timeout got=none exp=frame_valid"); end
        end
    endtask

    task automatic pulse_rd_clear();
        @(negedge clk) pif.rd_clear = 1'b1;
        @(negedge clk) pif.rd_clear = 1'b0;
    endtask

    task automatic test_reset();
        int n; bit ok;
        rst = 1'b1;
        pif.rd_clear = 1'b0;
        pad_byte = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wait_latch(n, ok);
        total++;
        if (!ok || n != PDIV) begin bad++; $display("FAIL first_latch got=%0d exp=%0d", n, PDIV); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (pif.pad_latch !== 1'b0) begin bad++; $display("FAIL rst_latch got=%b exp=0", pif.pad_latch); end
        total++;
        if (pif.pad_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%b exp=0", pif.pad_pulse); end
        total++;
        if (pif.game_word !== 16'h0000) begin bad++; $display("FAIL rst_word got=%h exp=0000", pif.game_word); end
        total++;
        if (pif.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b exp=0", pif.frame_valid); end
        @(negedge clk) rst = 1'b0;
        wait_latch(n, ok);
        total++;
        if (!ok || n != PDIV) begin bad++; $display("FAIL relatch got=%0d exp=%0d", n, PDIV); end
    endtask

    task automatic test_press();
        int n; bit ok;
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== 16'h0000) begin bad++; $display("FAIL idle_frame got=%h exp=0000", pif.game_word); end
        pad_byte = 8'b1111_0110;
        skip_frames(EXTRA);
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== 16'h0909) begin bad++; $display("FAIL press_a_start got=%h exp=0909", pif.game_word); end
        @(posedge clk); #1;
        total++;
        if (pif.frame_valid !== 1'b0) begin bad++; $display("FAIL fv_width got=%b exp=0", pif.frame_valid); end
    endtask

    task automatic test_hold();
        int n; bit ok;
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== 16'h0909) begin bad++; $display("FAIL hold got=%h exp=0909", pif.game_word); end
        pulse_rd_clear();
        total++;
        if (pif.game_word !== 16'h0009) begin bad++; $display("FAIL rd_clear got=%h exp=0009", pif.game_word); end
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== 16'h0009) begin bad++; $display("FAIL hold_cleared got=%h exp=0009", pif.game_word); end
    endtask

    task automatic test_clear_at_commit();
        int n; bit ok;
        pad_byte = 8'hFF;
        skip_frames(EXTRA);
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== 16'h0000) begin bad++; $display("FAIL release got=%h exp=0000", pif.game_word); end
        pad_byte = 8'b1111_0110;
        skip_frames(EXTRA);
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== 16'h0909) begin bad++; $display("FAIL repress got=%h exp=0909", pif.game_word); end
        pad_byte = 8'b0111_1110;
        skip_frames(EXTRA);
        wait_latch(n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL collide_latch timeout got=none exp=latch"); end
        repeat (76) @(posedge clk);
        #1 pif.rd_clear = 1'b1;
        @(posedge clk);
        #1 pif.rd_clear = 1'b0;
        total++;
        if (pif.frame_valid !== 1'b1) begin bad++; $display("FAIL collide_fv got=%b exp=1", pif.frame_valid); end
        total++;
        if (pif.game_word !== 16'h8081) begin bad++; $display("FAIL collide_word got=%h exp=8081", pif.game_word); end
    endtask

    task automatic test_timing();
        int n; bit ok;
        int cyc, lat, rises;
        logic prev;
        wait_fv(n, ok);
        cyc = 0; lat = 0; rises = 0;
        prev = pif.pad_pulse;
        for (int i = 0; i < 2100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (pif.pad_latch) lat++;
            if (pif.pad_pulse && !prev) rises++;
            prev = pif.pad_pulse;
            if (pif.frame_valid) break;
        end
        total++;
        if (cyc != PDIV) begin bad++; $display("FAIL fv_period got=%0d exp=%0d", cyc, PDIV); end
        total++;
        if (lat != 2 * TICK) begin bad++; $display("FAIL latch_len got=%0d exp=%0d", lat, 2 * TICK); end
        total++;
        if (rises != 7) begin bad++; $display("FAIL pulse_rises got=%0d exp=7", rises); end
        total++;
        if (pif.game_word !== 16'h8081) begin bad++; $display("FAIL held_word got=%h exp=8081", pif.game_word); end
    endtask

    task automatic test_debounce();
        int n; bit ok;
        logic [15:0] e_glitch, e_back, e_first, e_second;
`ifdef PAD_DEBOUNCE_EN
        e_glitch = 16'h0081; e_back = 16'h0081; e_first = 16'h0081; e_second = 16'h0283;
`else
        e_glitch = 16'h0283; e_back = 16'h0281; e_first = 16'h0283; e_second = 16'h0283;
`endif
        pulse_rd_clear();
        total++;
        if (pif.game_word !== 16'h0081) begin bad++; $display("FAIL pre_glitch got=%h exp=0081", pif.game_word); end
        pad_byte = 8'b0111_1100;
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== e_glitch) begin bad++; $display("FAIL glitch got=%h exp=%h", pif.game_word, e_glitch); end
        pad_byte = 8'b0111_1110;
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== e_back) begin bad++; $display("FAIL glitch_end got=%h exp=%h", pif.game_word, e_back); end
        pulse_rd_clear();
        pad_byte = 8'b0111_1100;
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== e_first) begin bad++; $display("FAIL b_first got=%h exp=%h", pif.game_word, e_first); end
        wait_fv(n, ok);
        total++;
        if (!ok || pif.game_word !== e_second) begin bad++; $display("FAIL b_second got=%h exp=%h", pif.game_word, e_second); end
    endtask

    initial begin
        pif.rd_clear = 1'b0;
        test_reset();
        test_press();
        test_hold();
        test_clear_at_commit();
        test_timing();
        test_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
